soc_system_writedata_txd: RTL and testbench

//  Avalon-MM slave through which the HPS sends 32-bit TXD words to FPGA fabric; complements the RXD read-data PIO.

---
 rtl/soc_system_writedata_txd_pkg.sv | 34 +++
 rtl/soc_system_txd_fifo.sv | 76 +++++++
 rtl/soc_system_writedata_txd.sv | 114 +++++++++++
 tb/tb_soc_system_writedata_txd.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/soc_system_writedata_txd_pkg.sv
// ============================================================================
// soc_system_writedata_txd_pkg : register map and status packing for TXD port
// Rev 1.0
// ============================================================================
`default_nettype none

package soc_system_writedata_txd_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_DEPTH  = 2'd3
  } reg_addr_e;

  localparam int ST_EMPTY_BIT   = 9;
  localparam int ST_FULL_BIT    = 10;
  localparam int ST_OVF_BIT     = 11;
  localparam int CTRL_CLEAR_BIT = 0;
  localparam int CTRL_FLUSH_BIT = 1;

  localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

  function automatic logic [31:0] pack_status(input logic [8:0]  level,
                                              input logic        empty,
                                              input logic        full,
                                              input logic        ovf,
                                              input logic [15:0] drop_cnt);
    return {drop_cnt, 4'b0000, ovf, full, empty, level};
  endfunction

endpackage

`default_nettype wire

// File: rtl/soc_system_txd_fifo.sv
// ============================================================================
// soc_system_txd_fifo : synchronous show-ahead FIFO with flush
// Rev 1.0
// ============================================================================
`default_nettype none

module soc_system_txd_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);

  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              push_ok;
  logic              pop_ok;

  assign full  = (level_q == (ADDR_W+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & (~full | pop_ok) & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + (ADDR_W+1)'(1);
        2'b01:   level_d = level_q - (ADDR_W+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/soc_system_writedata_txd.sv
// ============================================================================
// soc_system_writedata_txd : Avalon-MM TXD write port buffered onto a stream
// Rev 1.0
// ============================================================================
`default_nettype none

module soc_system_writedata_txd
  import soc_system_writedata_txd_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  logic              wr_en;
  logic              push;
  logic              ctrl_wr;
  logic              flush;
  logic              clear;
  logic              pop;
  logic              drop;
  logic [31:0]       head;
  logic [ADDR_W:0]   level;
  logic [8:0]        level_ext;
  logic              full;
  logic              empty;

  logic              overflow_q, overflow_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic [31:0]       readdata_q, readdata_d;

  assign wr_en   = chipselect & ~write_n;
  assign push    = wr_en & (address == REG_DATA);
  assign ctrl_wr = wr_en & (address == REG_CTRL);
  assign flush   = ctrl_wr & writedata[CTRL_FLUSH_BIT];
  assign clear   = ctrl_wr & writedata[CTRL_CLEAR_BIT];
  assign pop     = out_valid & out_ready;
  assign drop    = push & full & ~pop;

  soc_system_txd_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (writedata),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = ~empty;
  assign out_data  = head;

  always_comb begin
    level_ext = '0;
    level_ext[ADDR_W:0] = level;
  end

  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clear) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != DROP_CNT_MAX) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Read data reflects state before the edge; there is no read strobe.
  always_comb begin
    readdata_d = '0;
    case (reg_addr_e'(address))
      REG_DATA:   readdata_d = empty ? 32'd0 : head;
      REG_STATUS: readdata_d = pack_status(level_ext, empty, full, overflow_q, drop_cnt_q);
      REG_CTRL:   readdata_d = '0;
      REG_DEPTH:  readdata_d = 32'(DEPTH);
      default:    readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      readdata_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

endmodule

`default_nettype wire

// File: tb/tb_soc_system_writedata_txd.sv
// ============================================================================
// tb_soc_system_writedata_txd : directed scoreboard bench for the TXD port
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_soc_system_writedata_txd;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd;

  soc_system_writedata_txd #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic push_word(input logic [31:0] d, input bit kept);
    bus_write(2'd0, d);
    if (kept) exp_q.push_back(d);
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  // Monitor: a word leaves the DUT at the next edge whenever valid & ready.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("stream_unexpected", out_data, 32'hxxxx_xxxx);
      end else begin
        check("stream_word", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset state
    tick(); tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    reset = 1'b0;
    read_reg(2'd1, rd); check("rst_status", rd, 32'h0000_0200);
    read_reg(2'd3, rd); check("depth_reg", rd, 32'd16);
    read_reg(2'd2, rd); check("ctrl_reads_zero", rd, 32'd0);

    // Single word, latency 1
    push_word(32'hA5A5_0001, 1'b1);
    check("one_valid", {31'd0, out_valid}, 32'd1);
    check("one_data", out_data, 32'hA5A5_0001);
    read_reg(2'd1, rd); check("one_status", rd, 32'h0000_0001);
    read_reg(2'd0, rd); check("one_peek", rd, 32'hA5A5_0001);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    read_reg(2'd1, rd); check("one_drained", rd, 32'h0000_0200);
    read_reg(2'd0, rd); check("empty_peek", rd, 32'd0);

    // Fill to full, then overflow
    for (int i = 0; i < 16; i++) push_word(32'(i), 1'b1);
    read_reg(2'd1, rd); check("full_status", rd, 32'h0000_0410);
    push_word(32'd99, 1'b0);
    read_reg(2'd1, rd); check("ovf_status", rd, 32'h0001_0C10);
    read_reg(2'd0, rd); check("ovf_head", rd, 32'd0);

    // Push while full with simultaneous pop is accepted
    out_ready = 1'b1;
    push_word(32'hDEAD_BEEF, 1'b1);
    out_ready = 1'b0;
    read_reg(2'd1, rd); check("full_push_pop", rd, 32'h0001_0C10);
    out_ready = 1'b1;
    repeat (16) tick();
    out_ready = 1'b0;
    check("drain_valid", {31'd0, out_valid}, 32'd0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    read_reg(2'd1, rd); check("sticky_ovf", rd, 32'h0001_0A00);
    bus_write(2'd2, 32'h1);
    read_reg(2'd1, rd); check("clear_status", rd, 32'h0000_0200);

    // Continuous streaming
    out_ready = 1'b1;
    push_word(32'h1111_0001, 1'b1);
    push_word(32'h2222_0002, 1'b1);
    push_word(32'h3333_0003, 1'b1);
    tick();
    check("stream_done_valid", {31'd0, out_valid}, 32'd0);
    read_reg(2'd1, rd); check("stream_empty", rd, 32'h0000_0200);
    out_ready = 1'b0;
    check("stream_queue", 32'(exp_q.size()), 32'd0);

    // Flush and clear together
    for (int i = 0; i < 16; i++) push_word(32'h5000_0000 + 32'(i), 1'b1);
    push_word(32'hBAD0_0001, 1'b0);
    push_word(32'hBAD0_0002, 1'b0);
    read_reg(2'd1, rd); check("pre_flush_full", rd, 32'h0002_0C10);
    out_ready = 1'b1;
    repeat (11) tick();
    out_ready = 1'b0;
    read_reg(2'd1, rd); check("level5_status", rd, 32'h0002_0805);
    read_reg(2'd0, rd); check("level5_head", rd, 32'h5000_000B);
    bus_write(2'd2, 32'h3);
    exp_q.delete();
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    read_reg(2'd1, rd); check("flush_status", rd, 32'h0000_0200);

    // Reset mid-stream
    for (int i = 0; i < 4; i++) push_word(32'h7000_0000 + 32'(i), 1'b1);
    address = 2'd1;
    tick();
    check("pre_rst_status", readdata, 32'h0000_0004);
    reset = 1'b1;
    tick();
    exp_q.delete();
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_readdata", readdata, 32'd0);
    reset = 1'b0;
    read_reg(2'd1, rd); check("post_rst_status", rd, 32'h0000_0200);

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
